// File: rtl/ram_dma_master.sv
// ram_dma_master: moves a block of 16-bit words between a stream interface
// and a register-mapped RAM peripheral. Each word is addressed by writing
// the address register, then writing or reading the data register. Every bus
// strobe is followed by a programmable number of idle cycles.
module ram_dma_master #(
   parameter int RD_LAT = 2,   // cycles from read strobe to valid bus_dat_in (1..4)
   parameter int GAP    = 1    // idle bus cycles after every strobe (0..3)
) (
   input  logic        clk,
   input  logic        rst,
   // command
   input  logic        start,
   input  logic        cmd_dir,
   input  logic        cmd_init,
   input  logic [7:0]  cmd_addr,
   input  logic [7:0]  cmd_len_m1,
   output logic        busy,
   output logic        done,
   // write-data stream
   input  logic        src_valid,
   output logic        src_ready,
   input  logic [15:0] src_data,
   // read-data stream
   output logic        snk_valid,
   input  logic        snk_ready,
   output logic [15:0] snk_data,
   // peripheral bus
   output logic        bus_cs,
   output logic        bus_wr,
   output logic        bus_rd,
   output logic [3:0]  bus_addr,
   output logic [15:0] bus_dat_out,
   input  logic [15:0] bus_dat_in
);

   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] SETA  = 4'd1;
   localparam logic [3:0] WWAIT = 4'd2;
   localparam logic [3:0] WDAT  = 4'd3;
   localparam logic [3:0] RDAT  = 4'd4;
   localparam logic [3:0] RWAIT = 4'd5;
   localparam logic [3:0] HOLD  = 4'd6;
   localparam logic [3:0] GAPW  = 4'd7;
   localparam logic [3:0] INIT  = 4'd8;
   localparam logic [3:0] DONE  = 4'd9;

   // peripheral register offsets
   localparam logic [3:0] REG_WDATA = 4'h0;
   localparam logic [3:0] REG_RDATA = 4'h2;
   localparam logic [3:0] REG_ADDR  = 4'h4;
   localparam logic [3:0] REG_INIT  = 4'h8;

   // down-counter reload values (count reaches zero on the last cycle)
   localparam logic [1:0] GAP_LOAD = 2'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

   logic [3:0]  state, state_nxt;
   logic [3:0]  ret_state, ret_nxt;       // where GAPW goes when it expires
   logic [1:0]  gap_cnt, gap_nxt;
   logic [1:0]  lat_cnt, lat_nxt;
   logic [7:0]  cur_addr, addr_nxt;
   logic [7:0]  word_cnt, cnt_nxt;
   logic        dir, dir_nxt;
   logic [15:0] wdat, wdat_nxt;
   logic [15:0] rdat_nxt;

   logic        strobe_end;               // current state is a strobe
   logic [3:0]  strobe_tgt;               // state to reach after the gap
   logic [3:0]  word_tgt;                 // state after the current word completes

   logic        cs_nxt, wr_nxt, rd_nxt;
   logic [3:0]  baddr_nxt;
   logic [15:0] bdat_nxt;

   // next-state and datapath decisions
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_nxt  = state;
      ret_nxt    = ret_state;
      gap_nxt    = gap_cnt;
      lat_nxt    = lat_cnt;
      addr_nxt   = cur_addr;
      cnt_nxt    = word_cnt;
      dir_nxt    = dir;
      wdat_nxt   = wdat;
      rdat_nxt   = snk_data;
      strobe_end = 1'b0;
      strobe_tgt = IDLE;
      word_tgt   = (word_cnt == 8'd0) ? DONE : SETA;

      case (state)
         IDLE: begin
            if (start) begin
               dir_nxt   = cmd_dir;
               addr_nxt  = cmd_addr;
               cnt_nxt   = cmd_len_m1;
               state_nxt = cmd_init ? INIT : SETA;
            end
         end
         SETA: begin
            strobe_end = 1'b1;
            strobe_tgt = dir ? RDAT : WWAIT;
         end
         WWAIT: begin
            if (src_valid && src_ready) begin
               wdat_nxt  = src_data;
               state_nxt = WDAT;
            end
         end
         WDAT: begin
            strobe_end = 1'b1;
            strobe_tgt = word_tgt;
            addr_nxt   = cur_addr + 8'd1;
            if (word_cnt != 8'd0) cnt_nxt = word_cnt - 8'd1;
         end
         RDAT: begin
            strobe_end = 1'b1;
            strobe_tgt = RWAIT;
            lat_nxt    = LAT_LOAD;
         end
         RWAIT: begin
            if (lat_cnt == 2'd0) begin
               rdat_nxt  = bus_dat_in;
               state_nxt = HOLD;
            end else begin
               lat_nxt = lat_cnt - 2'd1;
            end
         end
         HOLD: begin
            if (snk_ready) begin
               state_nxt = word_tgt;
               addr_nxt  = cur_addr + 8'd1;
               if (word_cnt != 8'd0) cnt_nxt = word_cnt - 8'd1;
            end
         end
         GAPW: begin
            if (gap_cnt == 2'd0) state_nxt = ret_state;
            else                 gap_nxt   = gap_cnt - 2'd1;
         end
         INIT: begin
            strobe_end = 1'b1;
            strobe_tgt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // every strobe is followed by the idle gap before moving on
      if (strobe_end) begin
         if (GAP == 0) begin
            state_nxt = strobe_tgt;
         end else begin
            state_nxt = GAPW;
            ret_nxt   = strobe_tgt;
            gap_nxt   = GAP_LOAD;
         end
      end
   end

   // bus values decoded from the next state so the registered bus lines up with the state
   always_comb begin
      cs_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      rd_nxt    = 1'b0;
      baddr_nxt = 4'h0;
      bdat_nxt  = 16'h0000;
      case (state_nxt)
         SETA: begin
            cs_nxt    = 1'b1;
            wr_nxt    = 1'b1;
            baddr_nxt = REG_ADDR;
            bdat_nxt  = {8'h00, addr_nxt};
         end
         WDAT: begin
            cs_nxt    = 1'b1;
            wr_nxt    = 1'b1;
            baddr_nxt = REG_WDATA;
            bdat_nxt  = wdat_nxt;
         end
         RDAT: begin
            cs_nxt    = 1'b1;
            rd_nxt    = 1'b1;
            baddr_nxt = REG_RDATA;
         end
         INIT: begin
            cs_nxt    = 1'b1;
            wr_nxt    = 1'b1;
            baddr_nxt = REG_INIT;
         end
         default: ;
      endcase
   end

   // state, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset as well so an aborted command leaves nothing behind.
      if (rst) begin
         state       <= IDLE;
         ret_state   <= IDLE;
         gap_cnt     <= 2'd0;
         lat_cnt     <= 2'd0;
         cur_addr    <= 8'h00;
         word_cnt    <= 8'h00;
         dir         <= 1'b0;
         wdat        <= 16'h0000;
         snk_data    <= 16'h0000;
         busy        <= 1'b0;
         done        <= 1'b0;
         src_ready   <= 1'b0;
         snk_valid   <= 1'b0;
         bus_cs      <= 1'b0;
         bus_wr      <= 1'b0;
         bus_rd      <= 1'b0;
         bus_addr    <= 4'h0;
         bus_dat_out <= 16'h0000;
      end else begin
         state       <= state_nxt;
         ret_state   <= ret_nxt;
         gap_cnt     <= gap_nxt;
         lat_cnt     <= lat_nxt;
         cur_addr    <= addr_nxt;
         word_cnt    <= cnt_nxt;
         dir         <= dir_nxt;
         wdat        <= wdat_nxt;
         snk_data    <= rdat_nxt;
         busy        <= (state_nxt != IDLE) && (state_nxt != DONE);
         done        <= (state_nxt == DONE);
         src_ready   <= (state_nxt == WWAIT);
         snk_valid   <= (state_nxt == HOLD);
         bus_cs      <= cs_nxt;
         bus_wr      <= wr_nxt;
         bus_rd      <= rd_nxt;
         bus_addr    <= baddr_nxt;
         bus_dat_out <= bdat_nxt;
      end
   end

endmodule

// File: tb/tb_ram_dma_master.sv
// tb_ram_dma_master: directed and randomized commands against a transaction
// model that predicts the exact list of bus strobes and the read-data stream.
module tb_ram_dma_master;

   localparam int RD_LAT = 2;
   localparam int GAP    = 1;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        start      = 1'b0;
   logic        cmd_dir    = 1'b0;
   logic        cmd_init   = 1'b0;
   logic [7:0]  cmd_addr   = 8'h00;
   logic [7:0]  cmd_len_m1 = 8'h00;
   logic        busy, done;
   logic        src_valid  = 1'b0;
   logic        src_ready;
   logic [15:0] src_data   = 16'h0000;
   logic        snk_valid;
   logic        snk_ready  = 1'b1;
   logic [15:0] snk_data;
   logic        bus_cs, bus_wr, bus_rd;
   logic [3:0]  bus_addr;
   logic [15:0] bus_dat_out;
   logic [15:0] bus_dat_in = 16'h0000;

   ram_dma_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd_dir(cmd_dir), .cmd_init(cmd_init),
      .cmd_addr(cmd_addr), .cmd_len_m1(cmd_len_m1), .busy(busy), .done(done),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
      .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr),
      .bus_dat_out(bus_dat_out), .bus_dat_in(bus_dat_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   logic [31:0] log_q[$];      // strobes observed on the bus
   logic [31:0] exp_q[$];      // strobes predicted by the model
   logic [15:0] src_q[$];      // words offered on the write stream
   logic [15:0] rd_vals[$];    // fixed values the peripheral returns first
   logic [15:0] rd_exp[$];     // read values the sink must deliver, in order
   int          rd_due[$];
   logic [15:0] rd_pend[$];
   int          done_cnt    = 0;
   int          busy_cycles = 0;
   int          snk_cnt     = 0;
   int          src_mode    = 0;  // 0: valid whenever data queued, 1: random
   int          snk_mode    = 0;  // 0: always ready, 1: random, 2: ten-cycle stall
   int          stall_cnt   = 0;
   bit          prev_hold   = 1'b0;
   logic [15:0] prev_snk    = 16'h0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [3:0] a, input logic w, input logic r,
                                         input logic [15:0] d);
      return {10'd0, a, w, r, d};
   endfunction

   // stimulus driver: peripheral read data, write stream, sink ready
   initial forever begin
      logic [15:0] v;
      @(posedge clk);
      cyc++;
      #1;
      if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
         bus_dat_in = rd_pend.pop_front();
         void'(rd_due.pop_front());
      end
      if (bus_cs && bus_rd) begin
         v = (rd_vals.size() > 0) ? rd_vals.pop_front() : 16'($urandom);
         rd_due.push_back(cyc + RD_LAT);
         rd_pend.push_back(v);
         rd_exp.push_back(v);
         bus_dat_in = 16'hDEAD;
      end
      src_valid = (src_q.size() > 0) && (src_mode == 0 || $urandom_range(2) != 0);
      src_data  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
      case (snk_mode)
         0: snk_ready = 1'b1;
         1: snk_ready = 1'($urandom_range(1));
         default: begin
            if (snk_valid && stall_cnt < 10) begin
               snk_ready = 1'b0;
               stall_cnt++;
            end else begin
               snk_ready = 1'b1;
            end
         end
      endcase
   end

   // monitor: bus protocol, stream handshakes, strobe log
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (bus_cs) begin
            check("strobe_one_dir", 32'(bus_wr ^ bus_rd), 32'd1);
            check("strobe_while_snk_valid", 32'(snk_valid), 32'd0);
            log_q.push_back(pack(bus_addr, bus_wr, bus_rd, bus_dat_out));
         end else begin
            check("bus_idle_zero", 32'({bus_wr, bus_rd, bus_addr, bus_dat_out}), 32'd0);
         end
         if (prev_hold) begin
            check("snk_valid_held", 32'(snk_valid), 32'd1);
            check("snk_data_held", 32'(snk_data), 32'(prev_snk));
         end
         if (src_valid && src_ready && src_q.size() > 0) void'(src_q.pop_front());
         if (snk_valid && snk_ready) begin
            snk_cnt++;
            if (rd_exp.size() == 0) check("snk_unexpected", 32'(snk_valid), 32'd0);
            else                    check("snk_data", 32'(snk_data), 32'(rd_exp.pop_front()));
         end
         prev_hold = snk_valid && !snk_ready && !rst;
         prev_snk  = snk_data;
      end
   end

   // run one command and compare the bus and stream against the model
   task automatic run_cmd(input string name, input logic init, input logic dir,
                          input logic [7:0] addr, input logic [7:0] len_m1,
                          input bit poke_busy, input bit poke_done, input int exp_busy);
      logic [7:0] a;
      bit         seen;
      int         words;
      log_q.delete(); exp_q.delete(); rd_exp.delete();
      done_cnt = 0; busy_cycles = 0; snk_cnt = 0; stall_cnt = 0;
      words = int'(len_m1) + 1;
      if (!init && !dir) while (src_q.size() < words) src_q.push_back(16'($urandom));
      if (init) begin
         exp_q.push_back(pack(4'h8, 1'b1, 1'b0, 16'h0000));
      end else begin
         for (int i = 0; i < words; i++) begin
            a = 8'((int'(addr) + i) % 256);
            exp_q.push_back(pack(4'h4, 1'b1, 1'b0, {8'h00, a}));
            if (dir) exp_q.push_back(pack(4'h2, 1'b0, 1'b1, 16'h0000));
            else     exp_q.push_back(pack(4'h0, 1'b1, 1'b0, src_q[i]));
         end
      end

      @(posedge clk); #1;
      check({name, "_idle_before"}, 32'(busy), 32'd0);
      cmd_init = init; cmd_dir = dir; cmd_addr = addr; cmd_len_m1 = len_m1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cmd_init = 1'($urandom); cmd_dir = 1'($urandom);
      cmd_addr = 8'($urandom); cmd_len_m1 = 8'($urandom);
      check({name, "_busy_after_start"}, 32'(busy), 32'd1);
      if (poke_busy) begin
         cmd_init = 1'b0; cmd_dir = 1'b0; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end

      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      if (seen && poke_done) begin
         cmd_init = 1'b1; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0; cmd_init = 1'b0;
      end
      repeat (6) begin
         @(negedge clk);
         check({name, "_idle_after"}, 32'(busy), 32'd0);
      end
      check({name, "_done_count"}, 32'(done_cnt), 32'd1);
      if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
      check({name, "_n_strobes"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < log_q.size()) check($sformatf("%s_strobe%0d", name, i), log_q[i], exp_q[i]);
      check({name, "_words_read"}, 32'(snk_cnt), 32'((dir && !init) ? words : 0));
      check({name, "_rd_left"}, 32'(rd_exp.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctrl"}, 32'({busy, done, src_ready, snk_valid, bus_cs, bus_wr, bus_rd, bus_addr}), 32'd0);
      check({name, "_bus_dat"}, 32'(bus_dat_out), 32'd0);
      check({name, "_snk_data"}, 32'(snk_data), 32'd0);
   endtask

   initial begin
      bit hit;
      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      mon_en = 1'b1;

      // reset and start in the same cycle: reset wins
      log_q.delete();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1; cmd_init = 1'b0; cmd_dir = 1'b1; cmd_len_m1 = 8'd0;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("rst_start_busy", 32'(busy), 32'd0);
      end
      check("rst_start_strobes", 32'(log_q.size()), 32'd0);

      // three-word write, stream always valid
      src_q = {16'hA001, 16'hA002, 16'hA003};
      run_cmd("wr3", 1'b0, 1'b0, 8'h10, 8'd2, 1'b0, 1'b0, 15);

      // two-word read across the top of the address space
      rd_vals = {16'h5555, 16'h6666};
      run_cmd("rd_fe", 1'b0, 1'b1, 8'hFE, 8'd1, 1'b0, 1'b0, -1);
      run_cmd("rd_wrap", 1'b0, 1'b1, 8'hFF, 8'd1, 1'b0, 1'b0, -1);

      // sink stalls for ten cycles in the hold state
      snk_mode = 2;
      run_cmd("rd_stall", 1'b0, 1'b1, 8'h33, 8'd1, 1'b0, 1'b0, -1);
      check("rd_stall_cycles", 32'(stall_cnt), 32'd10);
      snk_mode = 0;

      // init access with a start pulse while busy, then a start during done
      run_cmd("init", 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, -1);
      run_cmd("wr_done_poke", 1'b0, 1'b0, 8'h80, 8'd0, 1'b0, 1'b1, -1);

      // reset during the second word of a write
      log_q.delete(); done_cnt = 0;
      src_q = {16'hB001, 16'hB002, 16'hB003};
      @(posedge clk); #1;
      cmd_init = 1'b0; cmd_dir = 1'b0; cmd_addr = 8'h40; cmd_len_m1 = 8'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (log_q.size() >= 3) hit = 1'b1;
      end
      check("abort_reached_word2", 32'(hit), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("abort");
      rst = 1'b0;
      src_q.delete(); rd_due.delete(); rd_pend.delete();
      repeat (20) @(negedge clk);
      check("abort_no_more_strobes", 32'(log_q.size()), 32'd3);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      run_cmd("after_abort", 1'b0, 1'b0, 8'h40, 8'd2, 1'b0, 1'b0, 15);

      // randomized commands with random stream pacing
      for (int n = 0; n < 14; n++) begin
         logic       r_init, r_dir;
         logic [7:0] r_addr, r_len;
         r_init = ($urandom_range(7) == 0);
         r_dir  = 1'($urandom);
         r_addr = ($urandom_range(3) == 0) ? 8'(8'hFC + 8'($urandom_range(3))) : 8'($urandom);
         r_len  = 8'($urandom_range(5));
         src_mode = $urandom_range(1);
         snk_mode = $urandom_range(1);
         run_cmd($sformatf("rnd%0d", n), r_init, r_dir, r_addr, r_len, 1'b0, 1'b0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_dma_master.md
RAM_DMA_MASTER -- requirements
Module: ram_dma_master

Interface
REQ-001 Parameter RD_LAT, 2, cycles from read strobe to bus_dat_in valid (1..4).
REQ-002 Parameter GAP, 1, idle bus cycles after every strobe (0..3).
REQ-003 clk  in  1  single system clock, all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle command pulse.
REQ-006 cmd_dir  in  1  0 = write RAM, 1 = read RAM.
REQ-007 cmd_init  in  1  1 = issue a single init access (overrides cmd_dir).
REQ-008 cmd_addr  in  8  first RAM word address.
REQ-009 cmd_len_m1  in  8  word count minus one (1..256 words).
REQ-010 busy  out  1  command in progress.
REQ-011 done  out  1  one-cycle pulse on command completion.
REQ-012 src_valid / src_ready / src_data  in/out/in  1/1/16  write-data stream.
REQ-013 snk_valid / snk_ready / snk_data  out/in/out  1/1/16  read-data stream.
REQ-014 bus_cs, bus_wr, bus_rd  out  1 each  peripheral strobes.
REQ-015 bus_addr  out  4  peripheral register offset.
REQ-016 bus_dat_out  out  16  data to peripheral; bus_dat_in  in  16  data from peripheral.

Function
REQ-017 Register map driven: 4'h0 write data (wr), 4'h2 read data (rd), 4'h4 set address (wr), 4'h8 init (wr).
REQ-018 States: IDLE, SETA, WWAIT, WDAT, RDAT, RWAIT, HOLD, GAPW, INIT, DONE.
REQ-019 Strobe = exactly one cycle with bus_cs=1 and exactly one of bus_wr/bus_rd=1; all outputs registered.
REQ-020 Outside a strobe cycle bus_cs=bus_wr=bus_rd=0, bus_addr=4'h0, bus_dat_out=16'h0000.
REQ-021 Every strobe is followed by GAP cycles in GAPW before the next state.
REQ-022 start accepted only in IDLE; ignored while busy=1; busy=1 from the cycle after acceptance through the cycle before done.
REQ-023 Command fields latched on acceptance; later changes have no effect.
REQ-024 Init: INIT strobe bus_addr=4'h8, bus_wr=1, bus_dat_out=0; then GAPW, DONE.
REQ-025 Per word: SETA strobe bus_addr=4'h4, bus_wr=1, bus_dat_out={8'h00, cur_addr}.
REQ-026 Write word: WWAIT with src_ready=1 (only state asserting it); on src_valid&src_ready capture src_data; next cycle WDAT strobe bus_addr=4'h0, bus_wr=1, bus_dat_out=captured word.
REQ-027 Write throughput with src_valid held 1 and GAP=1: 5 cycles per word (SETA, GAPW, WWAIT, WDAT, GAPW).
REQ-028 Read word: RDAT strobe bus_addr=4'h2, bus_rd=1; RWAIT RD_LAT cycles; bus_dat_in captured into snk_data on last RWAIT cycle; HOLD with snk_valid=1.
REQ-029 HOLD: snk_valid and snk_data stable until snk_ready=1; that cycle completes the word; no strobe issued while snk_valid=1.
REQ-030 cur_addr increments by 1 modulo 256 after each word; 8'hFF wraps to 8'h00 and transfer continues.
REQ-031 Word counter loaded with cmd_len_m1; command ends after the word where counter = 0; exactly cmd_len_m1+1 words transferred.
REQ-032 DONE lasts one cycle: done=1, busy=0, then IDLE; start in DONE cycle is ignored.
REQ-033 src_valid low in WWAIT stalls indefinitely with no strobes; no timeout.

Reset
REQ-034 rst=1 at posedge: state IDLE, busy=0, done=0, src_ready=0, snk_valid=0, snk_data=0, all bus outputs 0, counters 0.
REQ-035 rst mid-command aborts immediately; no further strobes; captured data discarded; no done pulse.
REQ-036 rst and start in same cycle: rst wins, command not accepted.

Verification
REQ-037 Write 3 words, cmd_addr=8'h10, src_valid held 1, data 16'hA001..A003 -> strobes 4/0010,0/A001,4/0011,0/A002,4/0012,0/A003; 15 cycles; one done.
REQ-038 Read 2 words at 8'hFE, snk_ready=1, model returns 16'h5555,16'h6666 after RD_LAT=2 -> SETA 00FE, 00FF; snk_data 5555, 6666; done once.
REQ-039 Read wrap: cmd_addr=8'hFF, len_m1=1 -> SETA data 00FF then 0000.
REQ-040 snk_ready low 10 cycles in HOLD -> snk_valid/snk_data stable, zero strobes, resumes on ready.
REQ-041 cmd_init=1 -> single strobe addr 4'h8 wr=1, done pulse; start during busy ignored.
REQ-042 rst asserted during second write word -> next cycle all outputs 0, no done, next start behaves as fresh command.
